// File: rtl/johnson_decoder.sv
// Johnson-code decoder for a 4-bit Johnson counter: decodes the position,
// flags illegal codes and out-of-sequence steps, and locks onto a clean sequence.
module johnson_decoder #(
  parameter int LOCK_COUNT = 2,
  parameter int ALLOW_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] jc_in,
  output logic [2:0] idx,
  output logic       idx_valid,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

  state_t     state;
  logic [2:0] match_cnt;
  logic [2:0] prev;
  logic       prev_valid;

  logic       dec_legal;
  logic [2:0] dec_idx;
  logic       is_succ;
  logic       is_hold;
  logic [7:0] err_inc;

  // Returns {legal, position}; non-Johnson patterns decode as not legal.
  function automatic logic [3:0] jc_decode(input logic [3:0] code);
    case (code)
      4'b0000: jc_decode = {1'b1, 3'd0};
      4'b0001: jc_decode = {1'b1, 3'd1};
      4'b0011: jc_decode = {1'b1, 3'd2};
      4'b0111: jc_decode = {1'b1, 3'd3};
      4'b1111: jc_decode = {1'b1, 3'd4};
      4'b1110: jc_decode = {1'b1, 3'd5};
      4'b1100: jc_decode = {1'b1, 3'd6};
      4'b1000: jc_decode = {1'b1, 3'd7};
      default: jc_decode = {1'b0, 3'd0};
    endcase
  endfunction

  always_comb begin
    {dec_legal, dec_idx} = jc_decode(jc_in);
    // 3-bit add wraps 7 -> 0, which is exactly the Johnson successor rule
    is_succ = (dec_idx == prev + 3'd1);
    is_hold = (dec_idx == prev) && (ALLOW_HOLD != 0);
    err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  assign locked = (state == TRACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      match_cnt  <= 3'd0;
      prev       <= 3'd0;
      prev_valid <= 1'b0;
      idx        <= 3'd0;
      idx_valid  <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      if (in_valid) begin
        if (!dec_legal) begin
          illegal    <= 1'b1;
          err_cnt    <= err_inc;
          state      <= HUNT;
          match_cnt  <= 3'd0;
          prev_valid <= 1'b0;
        end else begin
          idx        <= dec_idx;
          idx_valid  <= 1'b1;
          prev       <= dec_idx;
          prev_valid <= 1'b1;
          // Without a valid previous code there is nothing to compare against
          if (prev_valid) begin
            case (state)
              HUNT: begin
                if (is_succ) begin
                  if ({1'b0, match_cnt} + 4'd1 >= LOCK_TGT) begin
                    state     <= TRACK;
                    match_cnt <= 3'd0;
                  end else begin
                    match_cnt <= match_cnt + 3'd1;
                  end
                end else begin
                  match_cnt <= 3'd0;
                end
              end
              TRACK: begin
                if (!(is_succ || is_hold)) begin
                  seq_err   <= 1'b1;
                  err_cnt   <= err_inc;
                  state     <= HUNT;
                  match_cnt <= 3'd0;
                end else begin
                  state <= TRACK;
                end
              end
              default: begin
                state     <= HUNT;
                match_cnt <= 3'd0;
              end
            endcase
          end else begin
            match_cnt <= 3'd0;
          end
        end
      end else begin
        state <= state;
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized and directed bench for johnson_decoder; two instances (default and
// LOCK_COUNT=3/ALLOW_HOLD=0) are checked against a table-driven reference model.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [3:0] jc_in;

  logic [2:0] idx_a, idx_b;
  logic       iv_a, iv_b, ill_a, ill_b, se_a, se_b, lk_a, lk_b;
  logic [7:0] err_a, err_b;

  always #5 clk = ~clk;

  johnson_decoder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .jc_in(jc_in),
    .idx(idx_a), .idx_valid(iv_a), .illegal(ill_a), .seq_err(se_a),
    .locked(lk_a), .err_cnt(err_a)
  );

  johnson_decoder #(.LOCK_COUNT(3), .ALLOW_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .jc_in(jc_in),
    .idx(idx_b), .idx_valid(iv_b), .illegal(ill_b), .seq_err(se_b),
    .locked(lk_b), .err_cnt(err_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] jc_tab [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] bad_tab [8] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hD};
  int lock_n [2] = '{2, 3};
  bit hold_ok [2] = '{1'b1, 1'b0};

  // Reference state: position history in plain integers
  int m_idx [2], m_err [2], m_match [2], m_prev [2];
  bit m_iv [2], m_ill [2], m_se [2], m_track [2], m_pv [2];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int find_pos(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (jc_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step(input int k, input bit r, input bit v, input logic [3:0] c);
    int pos;
    if (r) begin
      m_idx[k] = 0; m_err[k] = 0; m_match[k] = 0; m_prev[k] = 0;
      m_iv[k] = 0; m_ill[k] = 0; m_se[k] = 0; m_track[k] = 0; m_pv[k] = 0;
      return;
    end
    m_iv[k] = 0; m_ill[k] = 0; m_se[k] = 0;
    if (!v) return;
    pos = find_pos(c);
    if (pos < 0) begin
      m_ill[k] = 1;
      if (m_err[k] < 255) m_err[k]++;
      m_track[k] = 0; m_match[k] = 0; m_pv[k] = 0;
      return;
    end
    m_iv[k] = 1;
    m_idx[k] = pos;
    if (m_pv[k]) begin
      if (!m_track[k]) begin
        if (pos == (m_prev[k] + 1) % 8) begin
          m_match[k]++;
          if (m_match[k] >= lock_n[k]) begin m_track[k] = 1; m_match[k] = 0; end
        end else m_match[k] = 0;
      end else if (!(pos == (m_prev[k] + 1) % 8 || (pos == m_prev[k] && hold_ok[k]))) begin
        m_se[k] = 1;
        if (m_err[k] < 255) m_err[k]++;
        m_track[k] = 0; m_match[k] = 0;
      end
    end
    m_prev[k] = pos;
    m_pv[k] = 1;
  endtask

  task automatic check_all();
    chk_eq("a.idx", 32'(idx_a), 32'(m_idx[0]));
    chk_eq("a.idx_valid", 32'(iv_a), 32'(m_iv[0]));
    chk_eq("a.illegal", 32'(ill_a), 32'(m_ill[0]));
    chk_eq("a.seq_err", 32'(se_a), 32'(m_se[0]));
    chk_eq("a.locked", 32'(lk_a), 32'(m_track[0]));
    chk_eq("a.err_cnt", 32'(err_a), 32'(m_err[0]));
    chk_eq("b.idx", 32'(idx_b), 32'(m_idx[1]));
    chk_eq("b.idx_valid", 32'(iv_b), 32'(m_iv[1]));
    chk_eq("b.illegal", 32'(ill_b), 32'(m_ill[1]));
    chk_eq("b.seq_err", 32'(se_b), 32'(m_se[1]));
    chk_eq("b.locked", 32'(lk_b), 32'(m_track[1]));
    chk_eq("b.err_cnt", 32'(err_b), 32'(m_err[1]));
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    rst = r; in_valid = v; jc_in = c;
    @(posedge clk);
    model_step(0, r, v, c);
    model_step(1, r, v, c);
    #1;
    check_all();
  endtask

  task automatic feed(input int pos);
    step(1'b0, 1'b1, jc_tab[pos % 8]);
  endtask

  initial begin
    int g, sel;
    rst = 1'b1; in_valid = 1'b0; jc_in = 4'h0;
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h3);

    // Lock-on, then 16 steps across the 7 -> 0 wrap
    feed(0); feed(1); feed(2);
    chk_eq("lockon.locked", 32'(lk_a), 32'd1);
    for (int i = 3; i < 19; i++) feed(i);
    chk_eq("wrap.err", 32'(err_a), 32'd0);

    // Skip 2 -> 4 while tracking
    feed(0); feed(1); feed(2); feed(3); feed(4); feed(5); feed(6); feed(7);
    feed(0); feed(1); feed(2); feed(4);
    chk_eq("skip.idx", 32'(idx_a), 32'd4);

    // Illegal code, then relock
    feed(5); feed(6); feed(7);
    step(1'b0, 1'b1, 4'h5);
    feed(0); feed(1); feed(2);
    chk_eq("relock.locked", 32'(lk_a), 32'd1);

    // Hold with gaps: 3, gap, 3, gap, 3
    feed(3); feed(4); feed(5); feed(6); feed(7); feed(0); feed(1); feed(2);
    feed(3); step(1'b0, 1'b0, 4'hA); feed(3); step(1'b0, 1'b0, 4'h5); feed(3);

    // Reset while tracking drops lock with no error pulse
    feed(4); feed(5); feed(6);
    step(1'b1, 1'b1, 4'h5);

    // Randomized mix of successors, holds, skips, gaps, illegal codes, resets
    g = 0;
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) step(1'b1, 1'($urandom_range(0, 1)), jc_tab[g]);
      else if (sel < 14) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      else if (sel < 20) step(1'b0, 1'b1, bad_tab[$urandom_range(0, 7)]);
      else if (sel < 28) feed(g);
      else if (sel < 34) begin g = (g + $urandom_range(2, 7)) % 8; feed(g); end
      else begin g = (g + 1) % 8; feed(g); end
    end

    // Saturation, then reset mid-stream
    for (int n = 0; n < 300; n++) step(1'b0, 1'b1, bad_tab[n % 8]);
    chk_eq("sat.err_a", 32'(err_a), 32'd255);
    chk_eq("sat.err_b", 32'(err_b), 32'd255);
    step(1'b1, 1'b1, 4'h9);
    chk_eq("rst.err_a", 32'(err_a), 32'd0);
    feed(0); feed(1); feed(2); feed(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
